byte_frame_sync: RTL and testbench

//   Downstream consumer of the 8-bit registered byte stream (d->q register stage).

---
 rtl/byte_frame_sync.sv | 133 +++++++++++++
 tb/tb_byte_frame_sync.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_frame_sync.sv
// Hunts for a two-byte sync header, then captures and re-emits a fixed-length payload
// with start/end-of-frame markers, a frame counter and error/timeout pulses.
module byte_frame_sync #(
  parameter logic [7:0]  SYNC0       = 8'hAA,
  parameter logic [7:0]  SYNC1       = 8'h55,
  parameter int unsigned PAYLOAD_LEN = 4,
  parameter int unsigned MAX_GAP     = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_sof,
  output logic             out_eof,
  output logic             locked,
  output logic             sync_err,
  output logic             abort,
  output logic [CNT_W-1:0] frame_count
);

  localparam int unsigned IdxW = $clog2(PAYLOAD_LEN + 1);
  localparam int unsigned GapW = $clog2(MAX_GAP + 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(PAYLOAD_LEN - 1);
  localparam logic [GapW-1:0] GapLimit = GapW'(MAX_GAP);

  typedef enum logic [1:0] {StHunt, StGot0, StPayload} state_e;

  state_e            r_state, w_state_d;
  logic [IdxW-1:0]   r_idx, w_idx_d;
  logic [GapW-1:0]   r_gap, w_gap_d;
  logic              r_out_valid, w_out_valid_d;
  logic [7:0]        r_out_data, w_out_data_d;
  logic              r_sof, w_sof_d;
  logic              r_eof, w_eof_d;
  logic              r_sync_err, w_sync_err_d;
  logic              r_abort, w_abort_d;
  logic [CNT_W-1:0]  r_frame_count, w_frame_count_d;

  always_comb begin
    w_state_d       = r_state;
    w_idx_d         = r_idx;
    w_gap_d         = r_gap;
    w_out_valid_d   = 1'b0;
    w_out_data_d    = '0;
    w_sof_d         = 1'b0;
    w_eof_d         = 1'b0;
    w_sync_err_d    = 1'b0;
    w_abort_d       = 1'b0;
    w_frame_count_d = r_frame_count;

    case (r_state)
      StHunt: begin
        if (in_valid && in_data == SYNC0) w_state_d = StGot0;
      end
      StGot0: begin
        if (in_valid) begin
          if (in_data == SYNC1) begin
            w_state_d = StPayload;
            w_idx_d   = '0;
            w_gap_d   = '0;
          end else if (in_data != SYNC0) begin
            w_state_d    = StHunt;
            w_sync_err_d = 1'b1;
          end
        end
      end
      StPayload: begin
        if (in_valid) begin
          w_out_valid_d = 1'b1;
          w_out_data_d  = in_data;
          w_sof_d       = (r_idx == '0);
          w_eof_d       = (r_idx == LastIdx);
          w_gap_d       = '0;
          if (r_idx == LastIdx) begin
            w_idx_d         = '0;
            w_frame_count_d = r_frame_count + CNT_W'(1);
            w_state_d       = StHunt;
          end else begin
            w_idx_d = r_idx + IdxW'(1);
          end
        end else if (r_gap + GapW'(1) == GapLimit) begin
          // Gap timeout drops the partial frame without an end marker.
          w_state_d = StHunt;
          w_abort_d = 1'b1;
          w_gap_d   = '0;
          w_idx_d   = '0;
        end else begin
          w_gap_d = r_gap + GapW'(1);
        end
      end
      default: w_state_d = StHunt;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= StHunt;
      r_idx         <= '0;
      r_gap         <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_sof         <= 1'b0;
      r_eof         <= 1'b0;
      r_sync_err    <= 1'b0;
      r_abort       <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state       <= w_state_d;
      r_idx         <= w_idx_d;
      r_gap         <= w_gap_d;
      r_out_valid   <= w_out_valid_d;
      r_out_data    <= w_out_data_d;
      r_sof         <= w_sof_d;
      r_eof         <= w_eof_d;
      r_sync_err    <= w_sync_err_d;
      r_abort       <= w_abort_d;
      r_frame_count <= w_frame_count_d;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_sof     = r_sof;
  assign out_eof     = r_eof;
  assign locked      = (r_state == StPayload);
  assign sync_err    = r_sync_err;
  assign abort       = r_abort;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_byte_frame_sync.sv
// Randomised and directed bench for byte_frame_sync; two instances (CNT_W=8 and CNT_W=2)
// share one stimulus stream and are checked against a frame-level reference model.
module tb_byte_frame_sync;

  localparam int LEN = 4;
  localparam int GAP = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       out_valid_a, out_sof_a, out_eof_a, locked_a, sync_err_a, abort_a;
  logic [7:0] out_data_a, frame_count_a;
  logic       out_valid_b, out_sof_b, out_eof_b, locked_b, sync_err_b, abort_b;
  logic [7:0] out_data_b;
  logic [1:0] frame_count_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  byte_frame_sync #(.CNT_W(8)) u_dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid_a), .out_data(out_data_a), .out_sof(out_sof_a), .out_eof(out_eof_a),
    .locked(locked_a), .sync_err(sync_err_a), .abort(abort_a), .frame_count(frame_count_a)
  );

  byte_frame_sync #(.CNT_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_sof(out_sof_b), .out_eof(out_eof_b),
    .locked(locked_b), .sync_err(sync_err_b), .abort(abort_b), .frame_count(frame_count_b)
  );

  // Reference model: frame-level view of the stream (in frame or not, header half seen).
  bit         m_in_frame, m_seen0;
  int         m_pos, m_gap, m_frames;
  bit         m_valid, m_sof, m_eof, m_serr, m_abort;
  logic [7:0] m_data;

  task automatic model_reset();
    m_in_frame = 0; m_seen0 = 0; m_pos = 0; m_gap = 0; m_frames = 0;
    m_valid = 0; m_sof = 0; m_eof = 0; m_serr = 0; m_abort = 0; m_data = 8'h00;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d);
    m_valid = 0; m_sof = 0; m_eof = 0; m_serr = 0; m_abort = 0; m_data = 8'h00;
    if (m_in_frame) begin
      if (v) begin
        m_valid = 1; m_data = d;
        m_sof = (m_pos == 0);
        m_eof = (m_pos == LEN - 1);
        m_pos++;
        m_gap = 0;
        if (m_pos == LEN) begin
          m_in_frame = 0;
          m_frames++;
        end
      end else begin
        m_gap++;
        if (m_gap == GAP) begin
          m_in_frame = 0;
          m_abort = 1;
        end
      end
    end else if (v) begin
      if (m_seen0) begin
        if (d == 8'h55) begin
          m_in_frame = 1; m_seen0 = 0; m_pos = 0; m_gap = 0;
        end else if (d != 8'hAA) begin
          m_seen0 = 0; m_serr = 1;
        end
      end else if (d == 8'hAA) begin
        m_seen0 = 1;
      end
    end
  endtask

  function automatic logic [43:0] obs_all();
    return {out_valid_a, out_valid_a ? out_data_a : 8'h00, out_sof_a, out_eof_a, locked_a,
            sync_err_a, abort_a, frame_count_a,
            out_valid_b, out_valid_b ? out_data_b : 8'h00, out_sof_b, out_eof_b, locked_b,
            sync_err_b, abort_b, 6'b0, frame_count_b};
  endfunction

  function automatic logic [43:0] exp_all();
    logic [7:0] ca, cb;
    ca = 8'(m_frames);
    cb = 8'(m_frames % 4);
    return {m_valid, m_data, m_sof, m_eof, m_in_frame, m_serr, m_abort, ca,
            m_valid, m_data, m_sof, m_eof, m_in_frame, m_serr, m_abort, cb};
  endfunction

  task automatic drive_cycle(input bit v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    model_step(v, d);
  endtask

  task automatic apply_reset();
    in_valid = 0;
    reset = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (obs_all() !== 44'h0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs_all(), 44'h0);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 8'hAA);
      checks++;
      if (obs_all() !== exp_all()) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs_all(), exp_all());
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] s[$] = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] got[$];
    logic [7:0] want[$] = '{8'h01, 8'h02, 8'h03, 8'h04};
    int sof_at = -1, eof_at = -1;
    apply_reset();
    foreach (s[i]) begin
      drive_cycle(1, s[i]);
      checks++;
      if (obs_all() !== exp_all()) begin
        failures++;
        $display("FAIL basic cyc=%0d got=%h exp=%h", i, obs_all(), exp_all());
      end
      if (out_valid_a) begin
        if (out_sof_a) sof_at = got.size();
        if (out_eof_a) eof_at = got.size();
        got.push_back(out_data_a);
      end
    end
    checks++;
    if (got != want || sof_at != 0 || eof_at != 3) begin
      failures++;
      $display("FAIL basic_payload got_n=%0d sof=%0d eof=%0d exp_n=4 sof=0 eof=3",
               got.size(), sof_at, eof_at);
    end
    checks++;
    if (frame_count_a !== 8'd1 || locked_a !== 1'b0) begin
      failures++;
      $display("FAIL basic_end count=%0d locked=%b exp count=1 locked=0",
               frame_count_a, locked_a);
    end
  endtask

  task automatic test_repeat_sync0();
    logic [7:0] s[$] = '{8'hAA, 8'hAA, 8'hAA, 8'h55, 8'h10, 8'h20, 8'h30, 8'h40};
    logic [7:0] got[$];
    logic [7:0] want[$] = '{8'h10, 8'h20, 8'h30, 8'h40};
    int n_serr = 0;
    apply_reset();
    foreach (s[i]) begin
      drive_cycle(1, s[i]);
      checks++;
      if (obs_all() !== exp_all()) begin
        failures++;
        $display("FAIL repeat_sync0 cyc=%0d got=%h exp=%h", i, obs_all(), exp_all());
      end
      if (sync_err_a) n_serr++;
      if (out_valid_a) got.push_back(out_data_a);
    end
    checks++;
    if (n_serr != 0 || got != want) begin
      failures++;
      $display("FAIL repeat_sync0_sum serr=%0d bytes=%0d exp serr=0 bytes=4", n_serr, got.size());
    end
  endtask

  task automatic test_sync_err();
    logic [7:0] s[$] = '{8'hAA, 8'h12, 8'h55, 8'h01, 8'h00};
    int n_serr = 0, n_valid = 0, n_locked = 0;
    apply_reset();
    foreach (s[i]) begin
      drive_cycle(1, s[i]);
      checks++;
      if (obs_all() !== exp_all()) begin
        failures++;
        $display("FAIL sync_err cyc=%0d got=%h exp=%h", i, obs_all(), exp_all());
      end
      if (sync_err_a) n_serr++;
      if (out_valid_a) n_valid++;
      if (locked_a) n_locked++;
    end
    checks++;
    if (n_serr != 1 || n_valid != 0 || n_locked != 0) begin
      failures++;
      $display("FAIL sync_err_sum serr=%0d valid=%0d locked=%0d exp 1 0 0",
               n_serr, n_valid, n_locked);
    end
  endtask

  task automatic test_gap();
    int n_abort = 0, n_eof = 0;
    apply_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 3 + 4 + (pass == 0 ? 3 : GAP); i++) begin
        if (i == 0)      drive_cycle(1, 8'hAA);
        else if (i == 1) drive_cycle(1, 8'h55);
        else if (i == 2) drive_cycle(1, 8'h01);
        else if (i < 3 + (pass == 0 ? 3 : GAP)) drive_cycle(0, 8'h00);
        else if (pass == 0) drive_cycle(1, 8'(i - 4));
        else drive_cycle(0, 8'h00);
        checks++;
        if (obs_all() !== exp_all()) begin
          failures++;
          $display("FAIL gap pass=%0d cyc=%0d got=%h exp=%h", pass, i, obs_all(), exp_all());
        end
        if (pass == 1 && abort_a) n_abort++;
        if (pass == 1 && out_eof_a) n_eof++;
      end
      if (pass == 0) begin
        checks++;
        if (frame_count_a !== 8'd1) begin
          failures++;
          $display("FAIL gap_short count=%0d exp=1", frame_count_a);
        end
      end
    end
    checks++;
    if (n_abort != 1 || n_eof != 0 || frame_count_a !== 8'd1 || locked_a !== 1'b0) begin
      failures++;
      $display("FAIL gap_abort abort=%0d eof=%0d count=%0d locked=%b exp 1 0 1 0",
               n_abort, n_eof, frame_count_a, locked_a);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] s[$] = '{8'hAA, 8'h55, 8'h05, 8'h06, 8'h07, 8'h08};
    apply_reset();
    drive_cycle(1, 8'hAA);
    drive_cycle(1, 8'h55);
    drive_cycle(1, 8'h01);
    drive_cycle(1, 8'h02);
    #2;
    reset = 0;
    #1;
    model_reset();
    checks++;
    if (obs_all() !== 44'h0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", obs_all(), 44'h0);
    end
    in_valid = 0;
    @(posedge clk);
    #3;
    reset = 1;
    foreach (s[i]) begin
      drive_cycle(1, s[i]);
      checks++;
      if (obs_all() !== exp_all()) begin
        failures++;
        $display("FAIL after_reset cyc=%0d got=%h exp=%h", i, obs_all(), exp_all());
      end
    end
    checks++;
    if (frame_count_a !== 8'd1) begin
      failures++;
      $display("FAIL after_reset_count got=%0d exp=1", frame_count_a);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] s[$] = '{8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55};
    logic [1:0] seq[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [7:0] got[$];
    apply_reset();
    for (int f = 0; f < 5; f++) begin
      got.delete();
      foreach (s[i]) begin
        drive_cycle(1, s[i]);
        checks++;
        if (obs_all() !== exp_all()) begin
          failures++;
          $display("FAIL wrap f=%0d cyc=%0d got=%h exp=%h", f, i, obs_all(), exp_all());
        end
        if (out_valid_b) got.push_back(out_data_b);
      end
      checks++;
      if (frame_count_b !== seq[f] || got.size() != 4 || got[0] !== 8'hAA || got[1] !== 8'h55) begin
        failures++;
        $display("FAIL wrap_count f=%0d count=%0d bytes=%0d exp count=%0d bytes=4",
                 f, frame_count_b, got.size(), seq[f]);
      end
    end
  endtask

  task automatic test_random();
    int n_bad = 0;
    bit v;
    logic [7:0] d;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        for (int k = 0; k < GAP + 1; k++) begin
          drive_cycle(0, 8'h00);
          checks++;
          if (obs_all() !== exp_all()) begin
            failures++;
            if (n_bad++ < 10) $display("FAIL random_gap i=%0d got=%h exp=%h", i, obs_all(), exp_all());
          end
        end
      end
      v = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0: d = 8'hAA;
        1: d = 8'h55;
        default: d = 8'($urandom);
      endcase
      drive_cycle(v, d);
      checks++;
      if (obs_all() !== exp_all()) begin
        failures++;
        if (n_bad++ < 10) $display("FAIL random i=%0d got=%h exp=%h", i, obs_all(), exp_all());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_repeat_sync0();
    test_sync_err();
    test_gap();
    test_async_reset();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
